// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : irq_controller
//  Purpose  : Prioritised interrupt controller in front of the multi-cycle CPU
//             control unit. Edge-detects N_IRQ maskable lines and one NMI line,
//             latches them as pending, and presents at most one maskable
//             request at a time. Handlers never nest: a new request is only
//             arbitrated after the previous one has been acknowledged and
//             closed with an end-of-interrupt.
//  Ports    :
//    clk, rst          - clock, synchronous active-high reset
//    irq[N_IRQ]        - maskable requests, rising-edge sensitive
//    nmi               - non-maskable request, rising-edge sensitive
//    mask_we/mask_wdata- mask register write port (1 = masked)
//    int_ack, nmi_ack  - service-entry pulses from the control unit
//    eoi               - end-of-interrupt pulse from the handler
//    int_req, nmi_req  - requests to the control unit
//    int_vec           - index presented / in service
//    pending, mask     - register readback
//    in_service        - a maskable handler is active
//  Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             nmi,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             nmi_ack,
  input  logic             eoi,
  output logic             int_req,
  output logic             nmi_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [N_IRQ-1:0] irq_q;
  logic             nmi_q;
  logic             nmi_pend;
  logic [N_IRQ-1:0] rise;
  logic             nmi_rise;
  logic [N_IRQ-1:0] avail;
  logic [VEC_W-1:0] arb_idx;
  logic             vec_load;
  logic             ack_ok;
  logic [N_IRQ-1:0] clr;

  assign rise     = irq & ~irq_q;
  assign nmi_rise = nmi & ~nmi_q;
  assign avail    = pending & ~mask;

  // An ack is only honoured while the request is actually visible; a pending
  // NMI hides int_req, so an ack in that window must not consume the request.
  assign ack_ok = (state == REQ) && int_ack && !nmi_pend;
  assign clr    = ack_ok ? (N_IRQ'(1) << int_vec) : '0;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    arb_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (avail[i]) begin
        arb_idx = VEC_W'(i);
      end
    end
  end

  // Edge detectors load the live inputs during reset so lines already high
  // at reset release do not register as new edges.
  always_ff @(posedge clk) begin
    irq_q <= irq;
    nmi_q <= nmi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      nmi_pend <= 1'b0;
      mask     <= '1;
    end else begin
      // Clear first, then set, so a fresh edge on the acknowledged line wins.
      pending  <= (pending & ~clr) | rise;
      nmi_pend <= nmi_rise | (nmi_pend & ~nmi_ack);
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      int_vec <= '0;
    end else begin
      state <= state_next;
      if (vec_load) begin
        int_vec <= arb_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    vec_load   = 1'b0;
    case (state)
      IDLE: begin
        // Arbitration is deferred while an NMI is outstanding.
        if ((avail != '0) && !nmi_pend) begin
          vec_load   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_ok) begin
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign int_req    = (state == REQ) && !nmi_pend;
  assign nmi_req    = nmi_pend;
  assign in_service = (state == SERVICE);

endmodule
`default_nettype wire
